gpr_regfile_adder: RTL and testbench

Integer register-file datapath slice for the single-cycle RV64 core: 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file, two combinational read ports, one synchronous write port, plus a DATA_WIDTH adder.
- Adder computes imm + rs1 value; this is the ADDI / address-generation path.
- Sits between decode (register indices, immediate) and write-back; write-back data and enable come from the execute stage.

---
 rtl/gpr_regfile_adder_if.sv | 27 ++
 rtl/gpr_regfile_adder.sv | 47 ++++
 tb/tb_gpr_regfile_adder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_regfile_adder_if.sv
// Bus bundle for gpr_regfile_adder: write port, two read ports and the imm + rs1 adder.
// The master side is decode/execute; the slave side is the register file slice.
interface gpr_regfile_adder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2, imm,
    input  rdata1, rdata2, sum, cout
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2, imm,
    output rdata1, rdata2, sum, cout
  );
endinterface

// File: rtl/gpr_regfile_adder.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file (x0 hardwired zero), two async read ports, one write port,
// plus the imm + rs1 adder. Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to reads.
module gpr_regfile_adder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic                clk,
  input logic                rst,
  gpr_regfile_adder_if.slave bus
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;

  // Reset wins over a simultaneous write; entry 0 is only ever cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wen && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Index 0 is decoded to zero explicitly so x0 is defined even before the first reset.
  assign stored1 = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
  assign stored2 = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];

`ifdef REGFILE_WRITE_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = bus.wen && !rst && (bus.waddr != '0);
  assign src1 = (bypass_ok && (bus.raddr1 == bus.waddr)) ? bus.wdata : stored1;
  assign src2 = (bypass_ok && (bus.raddr2 == bus.waddr)) ? bus.wdata : stored2;
`else
  assign src1 = stored1;
  assign src2 = stored2;
`endif

  assign bus.rdata1 = src1;
  assign bus.rdata2 = src2;
  assign {bus.cout, bus.sum} = {1'b0, bus.imm} + {1'b0, src1};
endmodule

// File: tb/tb_gpr_regfile_adder.sv
// Self-checking bench for gpr_regfile_adder: expected outputs are queued as stimulus is applied
// and popped once the combinational outputs have settled.
module tb_gpr_regfile_adder;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] sum;
    logic          cout;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;

  logic [DW-1:0] model [NR];
  obs_t          sb [$];
  obs_t          got;
  obs_t          want;

  gpr_regfile_adder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpr_regfile_adder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.r1   = bus.rdata1;
    o.r2   = bus.rdata2;
    o.sum  = bus.sum;
    o.cout = bus.cout;
    return o;
  endfunction

  function automatic void push_lit(logic [DW-1:0] r1, logic [DW-1:0] r2, logic [DW-1:0] s, logic c);
    obs_t e;
    e.r1   = r1;
    e.r2   = r2;
    e.sum  = s;
    e.cout = c;
    sb.push_back(e);
  endfunction

  // Expectation from the reference array plus the currently driven inputs.
  function automatic void push_model();
    obs_t        e;
    logic [DW:0] full;
    e.r1 = model[bus.raddr1];
    e.r2 = model[bus.raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.wen && !rst && (bus.waddr != '0)) begin
      if (bus.raddr1 == bus.waddr) e.r1 = bus.wdata;
      if (bus.raddr2 == bus.waddr) e.r2 = bus.wdata;
    end
`endif
    full   = {1'b0, bus.imm} + {1'b0, e.r1};
    e.sum  = full[DW-1:0];
    e.cout = full[DW];
    sb.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endfunction

  task automatic set_read(logic [AW-1:0] ra1, logic [AW-1:0] ra2, logic [DW-1:0] im);
    bus.raddr1 = ra1;
    bus.raddr2 = ra2;
    bus.imm    = im;
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d);
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    if (!rst && (a != '0)) model[a] = d;
  endtask

  task automatic test_reset();
    logic [DW-1:0] im;
    do_write(5'd5, 64'h1234);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    im = {$urandom(), $urandom()};
    set_read(5'd5, 5'd5, im);
    push_lit('0, '0, im, 1'b0);
    #1;
    got = observe();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL reset_clear: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
               got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
    end
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      set_read(AW'(i), AW'(NR - 1 - i), {$urandom(), $urandom()});
      push_model();
      #1;
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL reset_all[%0d]: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
                 i, got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
      end
    end
  endtask

  task automatic test_write_read();
    logic [AW-1:0] a;
    do_write(5'd3, 64'hDEADBEEF_00000001);
    set_read(5'd3, 5'd3, '0);
    push_lit(64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001, 1'b0);
    #1;
    got = observe();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL write_read_r3: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
               got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
    end
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(1, NR - 1));
      do_write(a, {$urandom(), $urandom()});
      set_read(a, AW'($urandom_range(0, NR - 1)), {$urandom(), $urandom()});
      push_model();
      #1;
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL write_read[%0d]: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
                 i, got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
      end
    end
  endtask

  task automatic test_x0();
    do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_read(5'd0, 5'd0, 64'd5);
    push_lit('0, '0, 64'd5, 1'b0);
    #1;
    got = observe();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL x0_hardwired: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
               got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
    end
  endtask

  // ADDI with a negative immediate, a positive one, then full-width wrap-around.
  task automatic test_adder();
    do_write(5'd1, 64'd10);
    do_write(5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: begin
          set_read(5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFB);
          push_lit(64'd10, '0, 64'd5, 1'b1);
        end
        1: begin
          set_read(5'd1, 5'd0, 64'd7);
          push_lit(64'd10, '0, 64'd17, 1'b0);
        end
        default: begin
          set_read(5'd2, 5'd1, 64'd1);
          push_lit(64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd0, 1'b1);
        end
      endcase
      #1;
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL adder[%0d]: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
                 p, got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] early;
`ifdef REGFILE_WRITE_BYPASS_EN
    early = 64'd9;
`else
    early = 64'd1;
`endif
    do_write(5'd4, 64'd1);
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin
          bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 64'd9;
          set_read(5'd4, 5'd4, '0);
          push_lit(early, early, early, 1'b0);
        end
        1: begin
          @(posedge clk);
          #1;
          bus.wen = 1'b0;
          push_lit(64'd9, 64'd9, 64'd9, 1'b0);
        end
        2: begin
          rst = 1'b1;
          bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 64'd77;
          push_lit(64'd9, 64'd9, 64'd9, 1'b0);
        end
        default: begin
          @(posedge clk);
          #1;
          bus.wen = 1'b0;
          rst = 1'b0;
          model_clear();
          push_lit('0, '0, '0, 1'b0);
        end
      endcase
      #1;
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL rdw_phase%0d: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
                 p, got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
      end
    end
  endtask

  // A write every cycle while reading random ports, including frequent same-index collisions.
  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, NR - 1));
      d = {$urandom(), $urandom()};
      bus.wen   = ($urandom_range(0, 3) != 0);
      bus.waddr = a;
      bus.wdata = d;
      set_read(($urandom_range(0, 1) == 1) ? a : AW'($urandom_range(0, NR - 1)),
               AW'($urandom_range(0, NR - 1)), {$urandom(), $urandom()});
      push_model();
      #1;
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL b2b[%0d]: got r1=%h r2=%h sum=%h cout=%b want r1=%h r2=%h sum=%h cout=%b",
                 i, got.r1, got.r2, got.sum, got.cout, want.r1, want.r2, want.sum, want.cout);
      end
      @(posedge clk);
      #1;
      if (bus.wen && (a != '0)) model[a] = d;
    end
    bus.wen = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    bus.wen    = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    bus.imm    = '0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_x0();
    test_adder();
    test_read_during_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
